// File: rtl/program_counter_if.sv
// Bus bundle for program_counter: decoded control inputs, branch target and
// fetch/status outputs. Clock and reset stay outside as plain ports.
interface program_counter_if #(
    parameter int unsigned D  = 12,
    parameter int unsigned CW = 16
);
    logic          start;
    logic          stall;
    logic          halt;
    logic          branch_en;
    logic          branch_abs;
    logic          cond_flag;
    logic [D-1:0]  target;
    logic          call_en;
    logic          ret_en;
    logic [D-1:0]  prog_ctr;
    logic          running;
    logic          done;
    logic [CW-1:0] cycle_count;

    modport master (
        output start, stall, halt, branch_en, branch_abs, cond_flag, target,
               call_en, ret_en,
        input  prog_ctr, running, done, cycle_count
    );

    modport slave (
        input  start, stall, halt, branch_en, branch_abs, cond_flag, target,
               call_en, ret_en,
        output prog_ctr, running, done, cycle_count
    );
endinterface

// File: rtl/program_counter.sv
// Fetch-address register with IDLE/RUN/HALTED sequencing, absolute/relative
// branches and a saturating RUN-cycle counter. Optional link register: PC_LINK_EN.
module program_counter #(
    parameter int unsigned D  = 12,
    parameter int unsigned CW = 16
) (
    input logic              Clk,
    input logic              Reset,
    program_counter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;

    state_e        state_q;
    logic [D-1:0]  prog_ctr_q;
    logic [D-1:0]  prog_ctr_d;
    logic [D-1:0]  pc_inc;
    logic [CW-1:0] cycle_q;
    logic [CW-1:0] cycle_d;
    logic          running_q;
    logic          done_q;
    logic          taken;

`ifdef PC_LINK_EN
    logic [D-1:0]  link_q;
    logic          link_we;
`else
    logic          unused_link_ports;
    assign unused_link_ports = bus.call_en ^ bus.ret_en;
`endif

    always_comb begin
        pc_inc  = prog_ctr_q + D'(1);
        taken   = bus.branch_en & bus.cond_flag;
        cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + CW'(1);

        // Unsigned D-bit add of a two's-complement offset wraps modulo 2^D
        prog_ctr_d = pc_inc;
        if (bus.halt || bus.stall)
            prog_ctr_d = prog_ctr_q;
`ifdef PC_LINK_EN
        else if (bus.ret_en)
            prog_ctr_d = link_q;
`endif
        else if (taken)
            prog_ctr_d = bus.branch_abs ? bus.target : prog_ctr_q + bus.target;

`ifdef PC_LINK_EN
        // call with ret: the jump uses the old link, the link takes pc+1
        link_we = !bus.halt && !bus.stall && bus.call_en && (taken || bus.ret_en);
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            prog_ctr_q <= '0;
            cycle_q    <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef PC_LINK_EN
            link_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, HALTED: begin
                    if (bus.start) begin
                        state_q    <= RUN;
                        prog_ctr_q <= '0;
                        cycle_q    <= '0;
                        running_q  <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                RUN: begin
                    cycle_q    <= cycle_d;
                    prog_ctr_q <= prog_ctr_d;
                    if (bus.halt) begin
                        state_q   <= HALTED;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
`ifdef PC_LINK_EN
                    if (link_we)
                        link_q <= pc_inc;
`endif
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prog_ctr    = prog_ctr_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.cycle_count = cycle_q;

endmodule
